// File: rtl/lab_seq_mult32_pkg.sv
// Shared definitions for the sequential shift-add multiplier: default width,
// control states and iteration-counter sizing.
package lab_seq_mult32_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit so the counter can hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_width(MULT_WIDTH);

endpackage

// File: rtl/lab_add33.sv
// Partial-product adder: adds the multiplicand to the upper product half when the
// current multiplier bit is set, keeping the carry as the extra MSB.
module lab_add33 import lab_seq_mult32_pkg::*; #(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_en,
  output logic [WIDTH:0]   o_sum
);

  logic [WIDTH:0] w_addend;

  assign w_addend = i_en ? {1'b0, i_a} : '0;
  assign o_sum    = {1'b0, i_acc} + w_addend;

endmodule

// File: rtl/lab_seq_mult32.sv
// Sequential unsigned shift-add multiplier; the multiplier is held in the low half
// of the product register and shifted out one bit per CALC step.
module lab_seq_mult32 import lab_seq_mult32_pkg::*; #(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [2*WIDTH:0]   out,
  output logic               out_valid,
  output state_t             o_dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [2*WIDTH:0] r_p;
  logic [CW-1:0]    r_cnt;
  logic             r_valid;
  logic [WIDTH:0]   w_sum;

  lab_add33 #(.WIDTH(WIDTH)) u_add (
    .i_acc (r_p[2*WIDTH-1:WIDTH]),
    .i_a   (r_a),
    .i_en  (r_p[0]),
    .o_sum (w_sum)
  );

  // Reset doubles as the start trigger: releasing it launches a new operation.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= LOAD;
      r_a     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_a     <= in_a;
          r_p     <= {{(WIDTH+1){1'b0}}, in_b};
          r_cnt   <= '0;
          r_state <= CALC;
        end
        CALC: begin
          r_p   <= {1'b0, w_sum, r_p[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= DONE;
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          r_valid <= 1'b1;
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign out         = r_p;
  assign out_valid   = r_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lab_seq_mult32.sv
// Self-checking bench for lab_seq_mult32: directed and random operands compared
// against a plain-arithmetic product model.
module tb_lab_seq_mult32;
  import lab_seq_mult32_pkg::*;

  localparam int W = 32;

  logic           CLK;
  logic           reset;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic [2*W:0]   out;
  logic           out_valid;
  state_t         o_dbg_state;

  int errors = 0;
  int checks = 0;
  logic [W:0] exp_q[$];

  lab_seq_mult32 #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .in_a        (in_a),
    .in_b        (in_b),
    .out         (out),
    .out_valid   (out_valid),
    .o_dbg_state (o_dbg_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input logic [2*W:0] obs, input logic [2*W:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    return {1'b0, prod};
  endfunction

  // Pulse reset asynchronously mid-cycle and check the cleared state at once.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check(out, '0, {tag, "_rst_out"});
    check({64'd0, out_valid}, '0, {tag, "_rst_valid"});
    check({63'd0, o_dbg_state}, {63'd0, LOAD}, {tag, "_rst_state"});
  endtask

  // Runs one operation from reset release; later input changes must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int edges;
    logic [2*W:0] exp_p;
    logic [2*W:0] held;
    exp_p = model(a, b);
    @(negedge CLK);
    pulse_reset(tag);
    in_a = a;
    in_b = b;
    @(negedge CLK);
    reset = 1'b0;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge CLK);
      #1;
      edges++;
      if (edges == 1) begin
        in_a = $urandom;
        in_b = $urandom;
      end
    end
    check({64'd0, out_valid}, 65'd1, {tag, "_valid"});
    check(65'(edges), 65'd33, {tag, "_latency"});
    check(out, exp_p, {tag, "_product"});
    check({64'd0, out[2*W]}, '0, {tag, "_msb"});
    check({63'd0, o_dbg_state}, {63'd0, DONE}, {tag, "_state"});
    held = out;
    repeat (3) @(negedge CLK);
    check(out, held, {tag, "_hold"});
  endtask

  initial begin
    reset = 1'b1;
    in_a  = '0;
    in_b  = '0;
    #1;
    check(out, '0, "por_out");
    check({64'd0, out_valid}, '0, "por_valid");

    run_op(32'd30,         32'd90,         "d_30x90");
    check(out, 65'd2700, "d_30x90_const");
    run_op(32'd30,         32'hFFFFFFA6,   "d_30xbig");
    check(out, 65'd128849016180, "d_30xbig_const");
    run_op(32'hFFFFFFE2,   32'd90,         "d_bigx90");
    check(out, 65'd386547053940, "d_bigx90_const");
    run_op(32'hFFFFFFE2,   32'hFFFFFFA6,   "d_bigxbig");
    check(out, 65'd18446743558313478796, "d_bigxbig_const");
    run_op(32'hFFFFFFFF,   32'hFFFFFFFF,   "d_max");
    check(out, 65'h0_FFFFFFFE_00000001, "d_max_const");
    run_op(32'd0,          32'd1,          "d_zero");
    run_op(32'd1,          32'hFFFFFFFF,   "d_one");
    run_op(32'h80000000,   32'd2,          "d_pow2");

    for (int i = 0; i < 12; i++) begin
      run_op($urandom, $urandom, $sformatf("rnd%0d", i));
    end

    // Abandon an operation mid-CALC, then restart with 7 x 6.
    @(negedge CLK);
    pulse_reset("mid_a");
    in_a = $urandom;
    in_b = $urandom;
    @(negedge CLK);
    reset = 1'b0;
    repeat (15) @(posedge CLK);
    pulse_reset("mid_abort");
    in_a = 32'd7;
    in_b = 32'd6;
    @(negedge CLK);
    reset = 1'b0;
    begin
      int edges;
      edges = 0;
      while (!out_valid && edges < 40) begin
        @(posedge CLK);
        #1;
        edges++;
      end
      check(65'(edges), 65'd33, "mid_latency");
      check(out, 65'd42, "mid_product");
      in_a = $urandom;
      in_b = $urandom;
      for (int k = 0; k < 10; k++) begin
        @(negedge CLK);
        check(out, 65'd42, "mid_stable");
        check({64'd0, out_valid}, 65'd1, "mid_valid_sticky");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
